// File: rtl/uc_seq.sv
// uc_seq: sequential control unit for the 8-bit microcontroller datapath.
// Define UC_ICOUNT_EN to build the 16-bit retired-instruction counter.
module uc_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        zero,
    input  logic        resume,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we,
    output logic        wez,
    output logic [2:0]  ALUOp,
    output logic        halted,
    output logic        waiting,
    output logic [15:0] icount
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic is_alu, is_li, is_j, is_jz, is_jnz, is_halt, is_wait;

    assign is_alu  = Opcode[5];
    assign is_li   = (Opcode[5:2] == 4'b0000);
    assign is_j    = (Opcode == 6'b000100);
    assign is_jz   = (Opcode == 6'b000101);
    assign is_jnz  = (Opcode == 6'b000110);
    assign is_halt = (Opcode == 6'b000111);
    assign is_wait = (Opcode[5:2] == 4'b0010);

    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        ALUOp   = 3'b000;
        halted  = 1'b0;
        waiting = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                unique case (1'b1)
                    is_alu: begin
                        ALUOp = Opcode[4:2];
                        we    = 1'b1;
                        wez   = 1'b1;
                    end
                    is_li: begin
                        s_inm = 1'b1;
                        we    = 1'b1;
                    end
                    is_j:   s_inc = 1'b0;
                    is_jz:  s_inc = ~zero;
                    is_jnz: s_inc = zero;
                    is_halt: begin
                        s_inc   = 1'b0;
                        state_d = ST_HALT;
                    end
                    is_wait: begin
                        // 4*(nn+1)-2 leaves the decode and exit cycles outside the countdown
                        s_inc   = 1'b0;
                        cnt_d   = {Opcode[1:0], 2'b10};
                        state_d = ST_WAIT;
                    end
                    default: ;
                endcase
            end
            ST_WAIT: begin
                waiting = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    s_inc = 1'b0;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                s_inc  = resume;
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (!reset) begin
            s_inc   = 1'b1;
            s_inm   = 1'b0;
            we      = 1'b0;
            wez     = 1'b0;
            ALUOp   = 3'b000;
            halted  = 1'b0;
            waiting = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef UC_ICOUNT_EN
    logic        retire;
    logic [15:0] icount_q, icount_d;

    assign retire = ((state_q == ST_RUN) && !is_halt && !is_wait)
                  || ((state_q == ST_WAIT) && (cnt_q == 4'd0))
                  || ((state_q == ST_HALT) && resume);

    assign icount_d = icount_q + 16'(retire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) icount_q <= 16'h0000;
        else        icount_q <= icount_d;
    end

    assign icount = icount_q;
`else
    assign icount = 16'h0000;
`endif

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: decode table, WAIT/HALT/reset sequences
// and randomized opcodes against a cycle-count reference model.
module tb_uc_seq;

    logic        clk;
    logic        reset;
    logic [5:0]  Opcode;
    logic        zero;
    logic        resume;
    logic        s_inc, s_inm, we, wez, halted, waiting;
    logic [2:0]  ALUOp;
    logic [15:0] icount;

    int checks = 0;
    int errors = 0;

    // reference model state
    int wait_left = 0;
    bit halt_m    = 0;
    int icnt      = 0;

    uc_seq dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
        .resume(resume), .s_inc(s_inc), .s_inm(s_inm), .we(we),
        .wez(wez), .ALUOp(ALUOp), .halted(halted), .waiting(waiting),
        .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic [6:0] ctl;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [15:0] ic_exp();
`ifdef UC_ICOUNT_EN
        return 16'(icnt & 32'hFFFF);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [24:0] actual();
        return {s_inc, s_inm, we, wez, ALUOp, halted, waiting, icount};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_out(input logic [5:0] op, input logic z,
                             input logic r, output logic [24:0] e);
        logic si, sm, w, wz, h, wt;
        logic [2:0] a;
        si = 1; sm = 0; w = 0; wz = 0; h = 0; wt = 0; a = 0;
        if (wait_left > 0) begin
            wt = 1;
            si = (wait_left == 1);
        end else if (halt_m) begin
            h  = 1;
            si = r;
        end else if (op[5]) begin
            a = op[4:2]; w = 1; wz = 1;
        end else if (op[5:2] == 4'b0000) begin
            sm = 1; w = 1;
        end else if (op == 6'd4 || op == 6'd7) begin
            si = 0;
        end else if (op == 6'd5) begin
            si = ~z;
        end else if (op == 6'd6) begin
            si = z;
        end else if (op[5:2] == 4'b0010) begin
            si = 0;
        end
        e = {si, sm, w, wz, a, h, wt, ic_exp()};
    endtask

    task automatic model_adv(input logic [5:0] op, input logic r);
        if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) icnt++;
        end else if (halt_m) begin
            if (r) begin
                halt_m = 0;
                icnt++;
            end
        end else if (op == 6'd7) begin
            halt_m = 1;
        end else if (op[5:2] == 4'b0010) begin
            wait_left = 4 * (int'(op[1:0]) + 1) - 1;
        end else begin
            icnt++;
        end
    endtask

    task automatic cyc(input logic [5:0] op, input logic z, input logic r,
                       input string nm, output logic [24:0] act);
        logic [24:0] e;
        Opcode = op; zero = z; resume = r;
        #1;
        model_out(op, z, r, e);
        act = actual();
        chk(nm, 32'(act), 32'(e));
        model_adv(op, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b0;
        #1;
        wait_left = 0; halt_m = 0; icnt = 0;
        chk(nm, 32'(actual()), 32'({7'b1000000, 2'b00, 16'h0000}));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [24:0] a;
    logic [7:0]  sinc_bits, wait_bits, we_bits;

    initial begin
        tbl[0]  = '{6'b100110, 1'b0, 7'b1011001};
        tbl[1]  = '{6'b111100, 1'b1, 7'b1011111};
        tbl[2]  = '{6'b000000, 1'b0, 7'b1110000};
        tbl[3]  = '{6'b000011, 1'b1, 7'b1110000};
        tbl[4]  = '{6'b000100, 1'b0, 7'b0000000};
        tbl[5]  = '{6'b000101, 1'b1, 7'b0000000};
        tbl[6]  = '{6'b000101, 1'b0, 7'b1000000};
        tbl[7]  = '{6'b000110, 1'b1, 7'b1000000};
        tbl[8]  = '{6'b000110, 1'b0, 7'b0000000};
        tbl[9]  = '{6'b001100, 1'b0, 7'b1000000};
        tbl[10] = '{6'b010101, 1'b1, 7'b1000000};
        tbl[11] = '{6'b011111, 1'b0, 7'b1000000};

        Opcode = 6'b100110; zero = 0; resume = 0; reset = 0;
        @(posedge clk);
        #1;
        do_reset("reset_outputs");

        for (int i = 0; i < 12; i++) begin
            Opcode = tbl[i].op; zero = tbl[i].z; resume = 1'b0;
            #1;
            chk($sformatf("table_ctl_%0d", i),
                32'({s_inc, s_inm, we, wez, ALUOp}), 32'(tbl[i].ctl));
            chk($sformatf("table_icount_%0d", i), 32'(icount), 32'(ic_exp()));
            model_adv(tbl[i].op, 1'b0);
            @(posedge clk);
            #1;
        end
`ifdef UC_ICOUNT_EN
        chk("table_icount_end", 32'(icount), 32'd12);
`else
        chk("table_icount_end", 32'(icount), 32'd0);
`endif

        // WAIT nn=1: eight cycles on the word
        for (int i = 0; i < 8; i++) begin
            cyc(6'b001001, 1'b0, 1'b0, "wait_seq", a);
            sinc_bits[i] = a[24];
            we_bits[i]   = a[22] | a[21];
            wait_bits[i] = a[16];
        end
        chk("wait_sinc_pattern", 32'(sinc_bits), 32'h80);
        chk("wait_waiting_pattern", 32'(wait_bits), 32'hFE);
        chk("wait_we_pattern", 32'(we_bits), 32'h00);
        cyc(6'b001100, 1'b0, 1'b0, "wait_after_nop", a);

        // HALT: resume in the decode cycle is ignored
        cyc(6'b000111, 1'b0, 1'b1, "halt_entry", a);
        chk("halt_entry_sinc", 32'(a[24]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(6'b000111, 1'b0, 1'b0, "halt_hold", a);
            chk("halt_hold_flag", 32'(a[17]), 32'd1);
        end
        cyc(6'b000111, 1'b0, 1'b1, "halt_resume", a);
        chk("halt_resume_sinc", 32'(a[24]), 32'd1);
        cyc(6'b001101, 1'b0, 1'b0, "halt_after", a);
        chk("halt_after_flag", 32'(a[17]), 32'd0);

        // reset in the middle of a WAIT
        for (int i = 0; i < 4; i++) cyc(6'b001011, 1'b0, 1'b0, "abort_wait", a);
        chk("abort_waiting_before", 32'(waiting), 32'd1);
        do_reset("abort_reset");
        cyc(6'b001100, 1'b0, 1'b0, "abort_after", a);

        // randomized opcodes
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = 6'($urandom);
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(4, 11));
            cyc(op, 1'($urandom), ($urandom_range(0, 3) == 0), "random", a);
        end
        while (halt_m || wait_left > 0) cyc(6'b001100, 1'b0, 1'b1, "drain", a);

        // icount wrap
`ifdef UC_ICOUNT_EN
        while ((icnt & 32'hFFFF) != 32'hFFFF) begin
            Opcode = 6'b001100; zero = 0; resume = 0;
            model_adv(6'b001100, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("wrap_preload", 32'(icount), 32'hFFFF);
`endif
        cyc(6'b001100, 1'b0, 1'b0, "wrap_nop", a);
        chk("wrap_result", 32'(icount), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
